demux_lane_widen: RTL
=====================

// Module: demux_lane_widen
// PURPOSE
//  Parametrised lane-widening demux. Gathers RATIO consecutive beats on each of
//  IN_LANES input lanes and presents them together on IN_LANES*RATIO parallel
//  output lanes, dividing the beat rate by RATIO. Runs on the fast lane clock
//  only; adds beat stall (en), phase re-alignment (sync) and an alignment-error flag.
//  Sits on the receive side between the lane deserialiser and the per-lane logic.
// PARAMETERS
//  WIDTH     8  data bits per lane
//  IN_LANES  2  input lanes (>=1)
//  RATIO     2  beats gathered per output group (>=2); PW=$clog2(RATIO) phase bits
//  OUT_HOLD  1  1: outputs hold between updates; 0: valid_out is 0 outside the strobe cycle
// PORTS
//  clk_2f     in   1                     fast lane clock; all logic on its rising edge
//  reset      in   1                     async, active-high; clears all state
//  en         in   1                     beat qualifier; 0 = no beat this cycle, phase holds
//  sync       in   1                     marks the current beat as phase 0 of a new group
//  data_in    in   IN_LANES*WIDTH        lane i = [i*WIDTH +: WIDTH]
//  valid_in   in   IN_LANES              lane i valid
//  data_out   out  IN_LANES*RATIO*WIDTH  out lane j = [j*WIDTH +: WIDTH]
//  valid_out  out  IN_LANES*RATIO        out lane j valid
//  out_strobe out  1                     1 cycle: new group on data_out/valid_out
//  align_err  out  1                     1 cycle: partial group discarded by sync
//  phase      out  PW                    current gather phase (debug/verification)
// BEHAVIOUR
//  - Reset (async, any time): data_out, valid_out, out_strobe, align_err, phase,
//    and the gather buffer go to 0 immediately. A partial group is dropped and
//    never emitted. Counting starts at phase 0 on the first beat after release.
//  - Beat: a rising edge with en=1. With en=0, nothing is captured. Phase,
//    buffer and outputs hold. out_strobe/align_err are 0 that cycle.
//  - Mapping: input lane i, beat phase p -> out lane j = i*RATIO + p
//    (the earliest beat goes to the lowest lane of each group).
//  - Phases 0..RATIO-2: {data,valid} of each lane are stored in buffer slot p.
//    phase <= p+1.
//  - Phase RATIO-1: on the same edge, data_out/valid_out <= buffer plus current
//    inputs. out_strobe <= 1. phase <= 0 (wrap).
//  - Latency: the group appears on the edge of its last beat. It is visible
//    the cycle after. out_strobe pulses exactly once per RATIO beats.
//  - valid_in is carried per beat and is not a gate. Invalid beats occupy their
//    slot with valid=0. Data of invalid beats is passed unmodified.
//  - sync=1 with a beat:
//    - If phase!=0, the buffered partial group is discarded (no strobe),
//      align_err <= 1, and the beat is stored as phase 0 (phase <= 1).
//    - If phase==0, there is no error and the beat proceeds normally.
//    - sync with en=0 is ignored.
//  - sync on the last-phase edge is the phase!=0 case: the group is discarded
//    and no strobe occurs.
//  - OUT_HOLD=0: valid_out is forced to 0 on the next edge without a strobe.
//    data_out holds.
//  - Registers are the gather buffer (IN_LANES*(RATIO-1)*(WIDTH+1)), the
//    outputs and the phase counter. The block has no combinational
//    input->output paths.
// TESTING (default params unless stated)
//  1. Reset, then beats 2 lanes: (A0,B0),(A1,B1),(A2,B2),(A3,B3), all valid
//     -> strobe after beats 2 and 4. out = {A0,A1,B0,B1} then {A2,A3,B2,B3}.
//     valid_out=4'hF.
//  2. en low for 3 cycles between beats 0 and 1 -> phase stays 1, no strobe.
//     The group still completes as {A0,A1,B0,B1}.
//  3. RATIO=4: sync asserted on beat 2 of a group -> align_err pulse. The next
//     strobe is 4 beats later with that beat in lane slot 0. No strobe for the
//     dropped group.
//  4. Reset asserted mid-group (phase=1), asynchronous to clk_2f -> outputs 0
//     immediately. After release, the first strobe is 2 beats later.
//  5. valid_in lane1=0 on beat 1 -> valid_out=4'b0111, data passed as given.
//  6. OUT_HOLD=0 -> valid_out nonzero only in strobe cycles. OUT_HOLD=1 ->
//     valid_out held. WIDTH=16, IN_LANES=4, RATIO=3 mapping check j=i*3+p.

Source files
------------

// File: rtl/demux_lane_widen_if.sv
// rtl/demux_lane_widen_if.sv - lane-widening demux port bundle: beat inputs and gathered group outputs
interface demux_lane_widen_if #(
    parameter int WIDTH    = 8,
    parameter int IN_LANES = 2,
    parameter int RATIO    = 2,
    parameter int PW       = $clog2(RATIO)
);
    logic                             en;
    logic                             sync;
    logic [IN_LANES*WIDTH-1:0]        data_in;
    logic [IN_LANES-1:0]              valid_in;
    logic [IN_LANES*RATIO*WIDTH-1:0]  data_out;
    logic [IN_LANES*RATIO-1:0]        valid_out;
    logic                             out_strobe;
    logic                             align_err;
    logic [PW-1:0]                    phase;

    modport master (
        output en, sync, data_in, valid_in,
        input  data_out, valid_out, out_strobe, align_err, phase
    );

    modport slave (
        input  en, sync, data_in, valid_in,
        output data_out, valid_out, out_strobe, align_err, phase
    );
endinterface

// File: rtl/demux_lane_widen.sv
// rtl/demux_lane_widen.sv - gathers RATIO beats per input lane into IN_LANES*RATIO parallel output lanes
module demux_lane_widen #(
    parameter int WIDTH    = 8,
    parameter int IN_LANES = 2,
    parameter int RATIO    = 2,
    parameter int OUT_HOLD = 1
) (
    input  logic             clk_2f,
    input  logic             reset,
    demux_lane_widen_if.slave bus
);
    localparam int PW = $clog2(RATIO);
    localparam int OL = IN_LANES * RATIO;
    localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);

    logic [PW-1:0]          phase_q;
    logic [WIDTH-1:0]       buf_data  [IN_LANES][RATIO-1];
    logic                   buf_valid [IN_LANES][RATIO-1];
    logic [OL*WIDTH-1:0]    data_out_q;
    logic [OL-1:0]          valid_out_q;
    logic                   strobe_q;
    logic                   err_q;
    logic [OL*WIDTH-1:0]    group_data;
    logic [OL-1:0]          group_valid;
    logic                   resync;
    logic                   complete;
    logic [PW-1:0]          slot;

    // A sync beat arriving mid-group restarts gathering at slot 0.
    assign resync   = bus.en && bus.sync && (phase_q != '0);
    assign slot     = resync ? '0 : phase_q;
    assign complete = bus.en && !resync && (phase_q == LAST_PHASE);

    genvar gi, gp;
    generate
        for (gi = 0; gi < IN_LANES; gi++) begin : g_lane
            for (gp = 0; gp < RATIO - 1; gp++) begin : g_slot
                assign group_data[(gi*RATIO+gp)*WIDTH +: WIDTH] = buf_data[gi][gp];
                assign group_valid[gi*RATIO+gp]                 = buf_valid[gi][gp];
            end
            assign group_data[(gi*RATIO+RATIO-1)*WIDTH +: WIDTH] = bus.data_in[gi*WIDTH +: WIDTH];
            assign group_valid[gi*RATIO+RATIO-1]                 = bus.valid_in[gi];
        end
    endgenerate

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= '0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < IN_LANES; i++) begin
                for (int s = 0; s < RATIO - 1; s++) begin
                    buf_data[i][s]  <= '0;
                    buf_valid[i][s] <= 1'b0;
                end
            end
        end else begin
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            if (OUT_HOLD == 0 && !complete) begin
                valid_out_q <= '0;
            end
            if (bus.en) begin
                err_q <= resync;
                if (complete) begin
                    data_out_q  <= group_data;
                    valid_out_q <= group_valid;
                    strobe_q    <= 1'b1;
                    phase_q     <= '0;
                end else begin
                    for (int i = 0; i < IN_LANES; i++) begin
                        for (int s = 0; s < RATIO - 1; s++) begin
                            if (slot == PW'(s)) begin
                                buf_data[i][s]  <= bus.data_in[i*WIDTH +: WIDTH];
                                buf_valid[i][s] <= bus.valid_in[i];
                            end
                        end
                    end
                    phase_q <= slot + PW'(1);
                end
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.out_strobe = strobe_q;
    assign bus.align_err  = err_q;
    assign bus.phase      = phase_q;
endmodule
